rot_mat_scheduler: RTL and testbench

- Shares one RotationZYXMat instance between NUM_REQ requesters, e.g. several scene objects needing their ZYX rotation matrix.
- Arbitrates round-robin, captures the winner's angles and drives rot_x/rot_y/rot_z with an inputEnable pulse.
- Waits for outputEnable, latches the nine matrix elements and returns them tagged with the requester id.
- A watchdog recovers the scheduler if the matrix unit never answers.

---
 rtl/rot_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/rot_mat_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_rot_mat_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotation-matrix scheduler: widths, state encoding
// and the fixed-point pi constant.
package rot_pkg;

  localparam int unsigned DECIMAL_BITS_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT
  } state_t;

  // Angle width: sign + 2 integer bits + fraction
  function automatic int unsigned ang_w(input int unsigned db);
    return db + 3;
  endfunction

  // Matrix element width: sign + 1 integer bit + fraction
  function automatic int unsigned m_w(input int unsigned db);
    return db + 2;
  endfunction

  // Ceiling log2, minimum 0
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // pi scaled by 2^(db-1), rounded to nearest
  function automatic int unsigned pi_2(input int unsigned db);
    return unsigned'($rtoi(3.141592653589793 * (2.0 ** (real'(db) - 1.0)) + 0.5));
  endfunction

  localparam int unsigned PI_2 = pi_2(DECIMAL_BITS_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_arbiter
  import rot_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    idx_c,
  output logic               valid_c
);

  // Scan NUM_REQ slots starting at ptr; first hit wins
  always_comb begin
    logic [ID_W-1:0] w_j;
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!valid_c && req[w_j]) begin
        valid_c = 1'b1;
        idx_c   = w_j;
        grant_c = NUM_REQ'(1) << w_j;
      end
    end
  end

endmodule

// File: rtl/rot_mat_scheduler.sv
// Shares one ZYX rotation-matrix unit among NUM_REQ requesters: round-robin
// grant, inputEnable burst, wait for outputEnable with watchdog, tagged result.
module rot_mat_scheduler
  import rot_pkg::*;
#(
  parameter  int unsigned DECIMAL_BITS = DECIMAL_BITS_DEF,
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned EN_CYCLES    = 4,
  parameter  int unsigned TIMEOUT      = 255,
  localparam int unsigned ANG_W        = ang_w(DECIMAL_BITS),
  localparam int unsigned M_W          = m_w(DECIMAL_BITS),
  localparam int unsigned ID_W         = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ANG_W-1:0] req_rot_x,
  input  logic [NUM_REQ*ANG_W-1:0] req_rot_y,
  input  logic [NUM_REQ*ANG_W-1:0] req_rot_z,
  output logic [NUM_REQ-1:0]       ack,
  output logic [ANG_W-1:0]         rot_x,
  output logic [ANG_W-1:0]         rot_y,
  output logic [ANG_W-1:0]         rot_z,
  output logic                     inputEnable,
  input  logic [M_W-1:0]           m_00,
  input  logic [M_W-1:0]           m_01,
  input  logic [M_W-1:0]           m_02,
  input  logic [M_W-1:0]           m_10,
  input  logic [M_W-1:0]           m_11,
  input  logic [M_W-1:0]           m_12,
  input  logic [M_W-1:0]           m_20,
  input  logic [M_W-1:0]           m_21,
  input  logic [M_W-1:0]           m_22,
  input  logic                     outputEnable,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [9*M_W-1:0]         res_mat,
  output logic                     err,
  output logic                     busy
);

  localparam int unsigned EN_W = 4;
  localparam int unsigned WD_W = 8;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr,    w_rr_ptr_nxt;
  logic [ID_W-1:0]    r_cur_id,    w_cur_id_nxt;
  logic [EN_W-1:0]    r_en_cnt,    w_en_cnt_nxt;
  logic [WD_W-1:0]    r_wd_cnt,    w_wd_cnt_nxt;
  logic [WD_W-1:0]    w_wd_inc;
  logic [NUM_REQ-1:0] r_ack,       w_ack_nxt;
  logic [ANG_W-1:0]   r_rot_x,     w_rot_x_nxt;
  logic [ANG_W-1:0]   r_rot_y,     w_rot_y_nxt;
  logic [ANG_W-1:0]   r_rot_z,     w_rot_z_nxt;
  logic               r_in_en,     w_in_en_nxt;
  logic               r_res_valid, w_res_valid_nxt;
  logic [ID_W-1:0]    r_res_id,    w_res_id_nxt;
  logic [9*M_W-1:0]   r_res_mat,   w_res_mat_nxt;
  logic               r_err,       w_err_nxt;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [ID_W-1:0]    w_arb_idx;
  logic               w_arb_valid;
  logic [9*M_W-1:0]   w_m_all;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (r_rr_ptr),
    .grant_c (w_arb_grant),
    .idx_c   (w_arb_idx),
    .valid_c (w_arb_valid)
  );

  assign w_m_all  = {m_22, m_21, m_20, m_12, m_11, m_10, m_02, m_01, m_00};
  assign w_wd_inc = r_wd_cnt + WD_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-register values
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_cur_id_nxt    = r_cur_id;
    w_en_cnt_nxt    = r_en_cnt;
    w_wd_cnt_nxt    = r_wd_cnt;
    w_ack_nxt       = '0;
    w_rot_x_nxt     = r_rot_x;
    w_rot_y_nxt     = r_rot_y;
    w_rot_z_nxt     = r_rot_z;
    w_in_en_nxt     = r_in_en;
    w_res_valid_nxt = 1'b0;
    w_res_id_nxt    = r_res_id;
    w_res_mat_nxt   = r_res_mat;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_rot_x_nxt  = req_rot_x[32'(w_arb_idx)*ANG_W +: ANG_W];
          w_rot_y_nxt  = req_rot_y[32'(w_arb_idx)*ANG_W +: ANG_W];
          w_rot_z_nxt  = req_rot_z[32'(w_arb_idx)*ANG_W +: ANG_W];
          w_ack_nxt    = w_arb_grant;
          w_cur_id_nxt = w_arb_idx;
          w_rr_ptr_nxt = ID_W'((32'(w_arb_idx) + 32'd1) % NUM_REQ);
          w_in_en_nxt  = 1'b1;
          w_en_cnt_nxt = EN_W'(1);
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_en_cnt == EN_W'(EN_CYCLES)) begin
          w_in_en_nxt  = 1'b0;
          w_wd_cnt_nxt = '0;
          w_state_nxt  = S_WAIT;
        end else begin
          w_en_cnt_nxt = r_en_cnt + EN_W'(1);
        end
      end
      S_WAIT: begin
        // Result beats watchdog when both land on the same edge
        if (outputEnable) begin
          w_res_mat_nxt   = w_m_all;
          w_res_id_nxt    = r_cur_id;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else if (w_wd_inc == WD_W'(TIMEOUT)) begin
          w_err_nxt    = 1'b1;
          w_res_id_nxt = r_cur_id;
          w_state_nxt  = S_IDLE;
        end else begin
          w_wd_cnt_nxt = w_wd_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cur_id    <= '0;
      r_en_cnt    <= '0;
      r_wd_cnt    <= '0;
      r_ack       <= '0;
      r_rot_x     <= '0;
      r_rot_y     <= '0;
      r_rot_z     <= '0;
      r_in_en     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_mat   <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_cur_id    <= w_cur_id_nxt;
      r_en_cnt    <= w_en_cnt_nxt;
      r_wd_cnt    <= w_wd_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_rot_x     <= w_rot_x_nxt;
      r_rot_y     <= w_rot_y_nxt;
      r_rot_z     <= w_rot_z_nxt;
      r_in_en     <= w_in_en_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_id    <= w_res_id_nxt;
      r_res_mat   <= w_res_mat_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign ack         = r_ack;
  assign rot_x       = r_rot_x;
  assign rot_y       = r_rot_y;
  assign rot_z       = r_rot_z;
  assign inputEnable = r_in_en;
  assign res_valid   = r_res_valid;
  assign res_id      = r_res_id;
  assign res_mat     = r_res_mat;
  assign err         = r_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rot_mat_scheduler.sv
// Scoreboard bench for rot_mat_scheduler with a stub matrix unit.
`timescale 1ns/1ps
module tb_rot_mat_scheduler;
  import rot_pkg::*;

  localparam int unsigned DB  = 8;
  localparam int unsigned NR  = 4;
  localparam int unsigned ENC = 4;
  localparam int unsigned TO  = 10;
  localparam int unsigned AW  = DB + 3;
  localparam int unsigned MW  = DB + 2;
  localparam int unsigned IW  = clog2(NR);

  typedef struct {
    int             id;
    logic [AW-1:0]  x, y, z;
  } ack_t;

  typedef struct {
    bit              is_err;
    int              id;
    logic [9*MW-1:0] mat;
  } res_t;

  logic                clk;
  logic                reset;
  logic [NR-1:0]       req;
  logic [NR*AW-1:0]    req_rot_x, req_rot_y, req_rot_z;
  logic [NR-1:0]       ack;
  logic [AW-1:0]       rot_x, rot_y, rot_z;
  logic                inputEnable;
  logic [MW-1:0]       m_in [9];
  logic                outputEnable;
  logic                res_valid;
  logic [IW-1:0]       res_id;
  logic [9*MW-1:0]     res_mat;
  logic                err;
  logic                busy;

  logic [AW-1:0]       ang_x [NR];
  logic [AW-1:0]       ang_y [NR];
  logic [AW-1:0]       ang_z [NR];
  logic [MW-1:0]       stub_m [9];
  logic [MW-1:0]       stray_m [9];
  logic                stub_oe, stray_oe;
  int                  stub_lat;

  ack_t                ack_q[$];
  res_t                res_q[$];
  int                  model_ptr;
  logic [9*MW-1:0]     model_last;
  int                  n_checks, n_fail;

  rot_mat_scheduler #(
    .DECIMAL_BITS (DB),
    .NUM_REQ      (NR),
    .EN_CYCLES    (ENC),
    .TIMEOUT      (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_rot_x    (req_rot_x),
    .req_rot_y    (req_rot_y),
    .req_rot_z    (req_rot_z),
    .ack          (ack),
    .rot_x        (rot_x),
    .rot_y        (rot_y),
    .rot_z        (rot_z),
    .inputEnable  (inputEnable),
    .m_00         (m_in[0]),
    .m_01         (m_in[1]),
    .m_02         (m_in[2]),
    .m_10         (m_in[3]),
    .m_11         (m_in[4]),
    .m_12         (m_in[5]),
    .m_20         (m_in[6]),
    .m_21         (m_in[7]),
    .m_22         (m_in[8]),
    .outputEnable (outputEnable),
    .res_valid    (res_valid),
    .res_id       (res_id),
    .res_mat      (res_mat),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack angle slots and select matrix source
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_rot_x[i*AW +: AW] = ang_x[i];
      req_rot_y[i*AW +: AW] = ang_y[i];
      req_rot_z[i*AW +: AW] = ang_z[i];
    end
    for (int k = 0; k < 9; k++) m_in[k] = stray_oe ? stray_m[k] : stub_m[k];
    outputEnable = stub_oe | stray_oe;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Arbitrary but deterministic element value the stub unit returns
  function automatic logic [MW-1:0] stub_fn(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                            input logic [AW-1:0] z, input int k);
    logic [31:0] v;
    v = 32'(x) * 32'(k + 1) + 32'(y) * 32'(k + 3) + (32'(z) << (k % 3)) + 32'(k * 37);
    return MW'(v);
  endfunction

  function automatic logic [9*MW-1:0] exp_mat(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                              input logic [AW-1:0] z);
    logic [9*MW-1:0] m;
    for (int k = 0; k < 9; k++) m[k*MW +: MW] = stub_fn(x, y, z, k);
    return m;
  endfunction

  task automatic rand_slot(input int i);
    ang_x[i] = AW'($urandom);
    ang_y[i] = AW'($urandom);
    ang_z[i] = AW'($urandom);
  endtask

  // Stub matrix unit: answers stub_lat edges after inputEnable falls (0 = never)
  initial begin : stub
    logic        ie_prev;
    bit          armed;
    int          cnt, lat;
    logic [AW-1:0] cx, cy, cz;
    ie_prev = 1'b0; armed = 1'b0; cnt = 0; lat = 0;
    cx = '0; cy = '0; cz = '0;
    stub_oe = 1'b0;
    for (int k = 0; k < 9; k++) stub_m[k] = '0;
    forever begin
      @(posedge clk); #1;
      stub_oe = 1'b0;
      if (ie_prev && !inputEnable) begin
        armed = (stub_lat != 0);
        lat   = stub_lat;
        cnt   = 1;
        cx = rot_x; cy = rot_y; cz = rot_z;
      end else if (armed) begin
        cnt++;
      end
      if (armed && cnt == lat) begin
        stub_oe = 1'b1;
        for (int k = 0; k < 9; k++) stub_m[k] = stub_fn(cx, cy, cz, k);
        armed = 1'b0;
      end
      ie_prev = inputEnable;
    end
  end

  // Monitor: compares every ack / result / err against the scoreboard queues
  initial begin : monitor
    int   cyc, ie_run, fall_cyc;
    logic ie_prev;
    ack_t a;
    res_t r;
    cyc = 0; ie_run = 0; fall_cyc = 0; ie_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        ie_run  = 0;
        ie_prev = 1'b0;
      end else begin
        if (ack != '0) begin
          if (ack_q.size() == 0) begin
            check("unexpected_ack", ack, 0);
          end else begin
            a = ack_q.pop_front();
            check("ack_onehot", ack, NR'(1) << a.id);
            check("ack_rot_x", rot_x, a.x);
            check("ack_rot_y", rot_y, a.y);
            check("ack_rot_z", rot_z, a.z);
            check("ack_ie_rise", {ie_prev, inputEnable}, 2'b01);
            check("ack_busy", busy, 1);
          end
        end
        if (inputEnable) begin
          ie_run++;
        end else if (ie_prev) begin
          check("ie_len", ie_run, ENC);
          ie_run   = 0;
          fall_cyc = cyc;
        end
        if (res_valid || err) begin
          if (res_q.size() == 0) begin
            check("unexpected_result", {res_valid, err}, 0);
          end else begin
            r = res_q.pop_front();
            check("res_kind", {res_valid, err}, r.is_err ? 2'b01 : 2'b10);
            check("res_id", res_id, r.id);
            check("res_mat", res_mat, r.mat);
            check("res_busy", busy, 0);
            if (err) check("err_delay", cyc - fall_cyc, TO);
          end
        end
        ie_prev = inputEnable;
      end
    end
  end

  // Issue a request mask; reference model derives the grant order and results
  task automatic run_batch(input logic [NR-1:0] mask, input int lat, input bit stray_issue);
    logic [NR-1:0] pend;
    int            order[$];
    int            p, id, j;
    bit            seen;
    ack_t          a;
    res_t          r;
    stub_lat = lat;
    pend = mask;
    p    = model_ptr;
    while (pend != '0) begin
      for (int k = 0; k < NR; k++) begin
        j = (p + k) % NR;
        if (pend[j]) begin
          order.push_back(j);
          pend[j] = 1'b0;
          p = (j + 1) % NR;
          break;
        end
      end
    end
    model_ptr = p;
    foreach (order[n]) begin
      id = order[n];
      a.id = id; a.x = ang_x[id]; a.y = ang_y[id]; a.z = ang_z[id];
      ack_q.push_back(a);
      r.is_err = (lat == 0);
      r.id     = id;
      if (lat != 0) model_last = exp_mat(ang_x[id], ang_y[id], ang_z[id]);
      r.mat    = model_last;
      res_q.push_back(r);
    end
    req = mask;
    foreach (order[n]) begin
      seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
        @(negedge clk);
        if (ack != '0) seen = 1'b1;
      end
      check("ack_wait", seen, 1);
      req[order[n]] = 1'b0;
      rand_slot(order[n]);
      if (stray_issue) begin
        for (int k = 0; k < 9; k++) stray_m[k] = MW'($urandom);
        stray_oe = 1'b1;
        @(negedge clk);
        stray_oe = 1'b0;
      end
    end
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check("idle_wait", seen, 1);
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rot_x"}, rot_x, 0);
    check({tag, "_rot_y"}, rot_y, 0);
    check({tag, "_rot_z"}, rot_z, 0);
    check({tag, "_ie"}, inputEnable, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_id"}, res_id, 0);
    check({tag, "_res_mat"}, res_mat, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    bit seen;
    logic [NR-1:0] mask;
    int lat;
    ack_t a;
    n_checks = 0; n_fail = 0;
    model_ptr = 0; model_last = '0;
    reset = 1'b1; req = '0; stray_oe = 1'b0; stub_lat = 6;
    for (int k = 0; k < 9; k++) stray_m[k] = '0;
    for (int i = 0; i < NR; i++) rand_slot(i);
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single request carrying pi
    ang_x[0] = AW'(PI_2); ang_y[0] = '0; ang_z[0] = '0;
    run_batch(4'b0001, 6, 1'b0);
    check("pi_passthrough", rot_x, 402);

    // Contention, then wrap-around pair
    run_batch(4'b1111, 6, 1'b0);
    run_batch(4'b1001, 4, 1'b0);

    // Timeout, then normal service
    run_batch(4'b0010, 0, 1'b0);
    run_batch(4'b0010, 3, 1'b0);

    // Result on the exact watchdog edge
    run_batch(4'b1000, TO, 1'b0);

    // Stray outputEnable in IDLE and during ISSUE
    for (int k = 0; k < 9; k++) stray_m[k] = MW'($urandom);
    stray_oe = 1'b1;
    @(negedge clk);
    stray_oe = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_idle_mat", res_mat, model_last);
    run_batch(4'b0001, 5, 1'b1);

    // Asynchronous reset while waiting for the unit
    stub_lat = TO;
    a.id = model_ptr <= 1 ? 1 : 1;
    a.x = ang_x[1]; a.y = ang_y[1]; a.z = ang_z[1];
    ack_q.push_back(a);
    req = 4'b0010;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (ack != '0) seen = 1'b1;
    end
    check("rst_ack_wait", seen, 1);
    req = '0;
    repeat (10) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    model_ptr = 0; model_last = '0;
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_res_mat", res_mat, 0);
    run_batch(4'b0100, 6, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 20; it++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      lat  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
      run_batch(mask, lat, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("ack_q_drained", ack_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
